// File: rtl/dma_w_arbiter.sv
// rtl/dma_w_arbiter.sv - round-robin arbiter sharing one DMA write channel between write aligners
module dma_w_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_MASTERS-1:0]             m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]      m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]      m_wdata,
    input  logic [N_MASTERS*(DATA_W/8)-1:0]  m_wstrb,
    input  logic [N_MASTERS*LEN_W-1:0]       m_len,
    output logic [N_MASTERS-1:0]             m_ready,
    output logic                             dma_w_valid,
    output logic [ADDR_W-1:0]                dma_w_addr,
    output logic [DATA_W-1:0]                dma_w_wdata,
    output logic [DATA_W/8-1:0]              dma_w_wstrb,
    output logic [LEN_W-1:0]                 dma_w_len,
    input  logic                             dma_w_ready,
    output logic [N_MASTERS-1:0]             grant,
    output logic                             busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       winner;
    logic [N_MASTERS-1:0]   grant_q;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       beat_cnt;

    logic [ADDR_W-1:0]      addr_a [N_MASTERS];
    logic [DATA_W-1:0]      data_a [N_MASTERS];
    logic [STRB_W-1:0]      strb_a [N_MASTERS];
    logic [LEN_W-1:0]       len_a  [N_MASTERS];

    for (genvar g = 0; g < N_MASTERS; g++) begin : g_unpack
        assign addr_a[g] = m_addr[g*ADDR_W +: ADDR_W];
        assign data_a[g] = m_wdata[g*DATA_W +: DATA_W];
        assign strb_a[g] = m_wstrb[g*STRB_W +: STRB_W];
        assign len_a[g]  = m_len[g*LEN_W +: LEN_W];
    end

    // Rotate requests so bit 0 is the rr_ptr master, then take the first set bit.
    logic [2*N_MASTERS-1:0] req_ext;
    logic [N_MASTERS-1:0]   req_rot;
    logic [IDX_W-1:0]       pick_off;
    logic                   pick_found;
    logic [IDX_W:0]         pick_sum;
    logic [IDX_W-1:0]       pick;

    assign req_ext = {m_valid, m_valid} >> rr_ptr;
    assign req_rot = req_ext[N_MASTERS-1:0];

    always_comb begin
        pick_off   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!pick_found && req_rot[i]) begin
                pick_off   = IDX_W'(i);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
        if (pick_sum >= (IDX_W+1)'(N_MASTERS)) begin
            pick_sum = pick_sum - (IDX_W+1)'(N_MASTERS);
        end
        pick = pick_sum[IDX_W-1:0];
    end

    logic [IDX_W-1:0] next_ptr;
    assign next_ptr = (winner == IDX_W'(N_MASTERS-1)) ? '0 : winner + 1'b1;

    always_comb begin
        dma_w_valid = 1'b0;
        dma_w_addr  = '0;
        dma_w_wdata = '0;
        dma_w_wstrb = '0;
        dma_w_len   = '0;
        m_ready     = '0;
        if (state == BURST) begin
            dma_w_valid = m_valid[winner];
            dma_w_addr  = addr_a[winner];
            dma_w_wdata = data_a[winner];
            dma_w_wstrb = strb_a[winner];
            dma_w_len   = len_q;
            m_ready     = grant_q & {N_MASTERS{dma_w_ready}};
        end
    end

    assign grant = grant_q;
    assign busy  = (state == BURST);

    logic hs;
    assign hs = (state == BURST) && dma_w_valid && dma_w_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            winner   <= '0;
            grant_q  <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_valid) begin
                        winner   <= pick;
                        grant_q  <= N_MASTERS'(1) << pick;
                        len_q    <= len_a[pick];
                        beat_cnt <= len_a[pick];
                        state    <= BURST;
                    end
                end
                BURST: begin
                    // Burst owner keeps the channel through valid gaps; only a handshake advances.
                    if (hs) begin
                        if (beat_cnt != '0) begin
                            beat_cnt <= beat_cnt - 1'b1;
                        end else begin
                            grant_q <= '0;
                            rr_ptr  <= next_ptr;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_w_arbiter.sv
// tb/tb_dma_w_arbiter.sv - directed table-driven bench for dma_w_arbiter with four masters
module tb_dma_w_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   m_valid;
    logic [127:0] m_addr;
    logic [127:0] m_wdata;
    logic [15:0]  m_wstrb;
    logic [31:0]  m_len;
    logic [3:0]   m_ready;
    logic         dma_w_valid;
    logic [31:0]  dma_w_addr;
    logic [31:0]  dma_w_wdata;
    logic [3:0]   dma_w_wstrb;
    logic [7:0]   dma_w_len;
    logic         dma_w_ready;
    logic [3:0]   grant;
    logic         busy;

    dma_w_arbiter #(
        .N_MASTERS(4),
        .ADDR_W(32),
        .DATA_W(32),
        .LEN_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m_valid(m_valid),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .m_wstrb(m_wstrb),
        .m_len(m_len),
        .m_ready(m_ready),
        .dma_w_valid(dma_w_valid),
        .dma_w_addr(dma_w_addr),
        .dma_w_wdata(dma_w_wdata),
        .dma_w_wstrb(dma_w_wstrb),
        .dma_w_len(dma_w_len),
        .dma_w_ready(dma_w_ready),
        .grant(grant),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] len;
        logic        ready;
        logic [3:0]  egrant;
        logic        edv;
        logic [3:0]  emr;
        logic [7:0]  elen;
    } vec_t;

    vec_t vecs[$];
    int   n_chk;
    int   n_fail;

    function automatic logic [31:0] addr_of(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h100;
    endfunction

    function automatic logic [31:0] data_of(input int i);
        return 32'hCAFE_0000 + 32'(i);
    endfunction

    function automatic logic [3:0] strb_of(input int i);
        logic [3:0] one;
        one = 4'h1;
        return one << i;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic [31:0] l, input logic rd,
                       input logic [3:0] g, input logic dv, input logic [3:0] mr, input logic [7:0] el);
        vec_t t;
        t.rst = r; t.valid = v; t.len = l; t.ready = rd;
        t.egrant = g; t.edv = dv; t.emr = mr; t.elen = el;
        vecs.push_back(t);
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] eg, input logic edv,
                                 input logic [3:0] emr, input logic [7:0] el);
        logic [31:0] ea, ed;
        logic [3:0]  es;
        ea = '0; ed = '0; es = '0;
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) begin
                ea = addr_of(i); ed = data_of(i); es = strb_of(i);
            end
        end
        chk({tag, " grant"}, 64'(grant), 64'(eg));
        chk({tag, " busy"}, 64'(busy), 64'(eg != 4'b0));
        chk({tag, " dma_w_valid"}, 64'(dma_w_valid), 64'(edv));
        chk({tag, " m_ready"}, 64'(m_ready), 64'(emr));
        chk({tag, " dma_w_len"}, 64'(dma_w_len), 64'(el));
        chk({tag, " dma_w_addr"}, 64'(dma_w_addr), 64'(ea));
        chk({tag, " dma_w_wdata"}, 64'(dma_w_wdata), 64'(ed));
        chk({tag, " dma_w_wstrb"}, 64'(dma_w_wstrb), 64'(es));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        m_valid = '0;
        m_len = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b0;
        m_valid = '0;
        m_len = '0;
        dma_w_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_addr[i*32 +: 32]  = addr_of(i);
            m_wdata[i*32 +: 32] = data_of(i);
            m_wstrb[i*4 +: 4]   = strb_of(i);
        end

        // single master len=3, with a mid-burst m_len change that must be ignored
        add(0, 4'b0000, 32'h0,   0, 4'b0000, 0, 4'b0000, 8'd0);
        add(1, 4'b0001, 32'h3,   1, 4'b0000, 0, 4'b0000, 8'd0);
        add(1, 4'b0001, 32'h3,   1, 4'b0001, 1, 4'b0001, 8'd3);
        add(1, 4'b0001, 32'h5,   1, 4'b0001, 1, 4'b0001, 8'd3);
        add(1, 4'b0001, 32'h5,   1, 4'b0001, 1, 4'b0001, 8'd3);
        add(1, 4'b0001, 32'h5,   1, 4'b0001, 1, 4'b0001, 8'd3);
        add(1, 4'b0000, 32'h0,   1, 4'b0000, 0, 4'b0000, 8'd0);
        // contention from reset, both len=1, then wrap back to master0
        add(0, 4'b0011, 32'h101, 1, 4'b0000, 0, 4'b0000, 8'd0);
        add(1, 4'b0011, 32'h101, 1, 4'b0000, 0, 4'b0000, 8'd0);
        add(1, 4'b0011, 32'h101, 1, 4'b0001, 1, 4'b0001, 8'd1);
        add(1, 4'b0011, 32'h101, 1, 4'b0001, 1, 4'b0001, 8'd1);
        add(1, 4'b0011, 32'h101, 1, 4'b0000, 0, 4'b0000, 8'd0);
        add(1, 4'b0011, 32'h101, 1, 4'b0010, 1, 4'b0010, 8'd1);
        add(1, 4'b0011, 32'h101, 1, 4'b0010, 1, 4'b0010, 8'd1);
        add(1, 4'b0001, 32'h101, 1, 4'b0000, 0, 4'b0000, 8'd0);
        add(1, 4'b0001, 32'h101, 1, 4'b0001, 1, 4'b0001, 8'd1);
        add(1, 4'b0000, 32'h101, 1, 4'b0001, 0, 4'b0001, 8'd1);
        add(1, 4'b0001, 32'h101, 1, 4'b0001, 1, 4'b0001, 8'd1);
        add(1, 4'b0000, 32'h0,   1, 4'b0000, 0, 4'b0000, 8'd0);
        // backpressure: master1 len=2, ready toggling
        add(1, 4'b0010, 32'h200, 1, 4'b0000, 0, 4'b0000, 8'd0);
        add(1, 4'b0010, 32'h200, 1, 4'b0010, 1, 4'b0010, 8'd2);
        add(1, 4'b0010, 32'h200, 0, 4'b0010, 1, 4'b0000, 8'd2);
        add(1, 4'b0010, 32'h200, 1, 4'b0010, 1, 4'b0010, 8'd2);
        add(1, 4'b0010, 32'h200, 0, 4'b0010, 1, 4'b0000, 8'd2);
        add(1, 4'b0010, 32'h200, 1, 4'b0010, 1, 4'b0010, 8'd2);
        add(1, 4'b0010, 32'h200, 1, 4'b0000, 0, 4'b0000, 8'd0);
        // valid gap on master0 while master2 waits
        add(0, 4'b0000, 32'h3,   1, 4'b0000, 0, 4'b0000, 8'd0);
        add(1, 4'b0101, 32'h3,   1, 4'b0000, 0, 4'b0000, 8'd0);
        add(1, 4'b0101, 32'h3,   1, 4'b0001, 1, 4'b0001, 8'd3);
        add(1, 4'b0100, 32'h3,   1, 4'b0001, 0, 4'b0001, 8'd3);
        add(1, 4'b0100, 32'h3,   1, 4'b0001, 0, 4'b0001, 8'd3);
        add(1, 4'b0101, 32'h3,   1, 4'b0001, 1, 4'b0001, 8'd3);
        add(1, 4'b0101, 32'h3,   1, 4'b0001, 1, 4'b0001, 8'd3);
        add(1, 4'b0101, 32'h3,   1, 4'b0001, 1, 4'b0001, 8'd3);
        add(1, 4'b0101, 32'h3,   1, 4'b0000, 0, 4'b0000, 8'd0);
        add(1, 4'b0101, 32'h3,   1, 4'b0100, 1, 4'b0100, 8'd0);
        add(1, 4'b0000, 32'h0,   1, 4'b0000, 0, 4'b0000, 8'd0);

        foreach (vecs[k]) begin
            @(negedge clk);
            rst         = vecs[k].rst;
            m_valid     = vecs[k].valid;
            m_len       = vecs[k].len;
            dma_w_ready = vecs[k].ready;
            #1;
            check_outputs($sformatf("row%0d", k), vecs[k].egrant, vecs[k].edv, vecs[k].emr, vecs[k].elen);
        end

        // round-robin fairness: all four requesting len=0 continuously
        do_reset();
        m_valid = 4'b1111;
        m_len = 32'h0;
        dma_w_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic [3:0] eg;
            logic [3:0] one;
            one = 4'b0001;
            eg = (k % 2 == 0) ? 4'b0000 : (one << (((k - 1) / 2) % 4));
            #1;
            chk($sformatf("rr%0d grant", k), 64'(grant), 64'(eg));
            @(negedge clk);
        end

        // reset mid-burst of master1 len=7, then pointer must restart at 0
        do_reset();
        dma_w_ready = 1'b1;
        m_valid = 4'b0001;
        m_len = 32'h0;
        #1;
        chk("mr idle grant", 64'(grant), 64'h0);
        @(negedge clk);
        #1;
        chk("mr m0 grant", 64'(grant), 64'h1);
        @(negedge clk);
        m_valid = 4'b0010;
        m_len = 32'h0000_0700;
        #1;
        chk("mr idle2 grant", 64'(grant), 64'h0);
        @(negedge clk);
        #1;
        check_outputs("mr beat1", 4'b0010, 1'b1, 4'b0010, 8'd7);
        @(negedge clk);
        #1;
        chk("mr beat2 grant", 64'(grant), 64'h2);
        #1;
        rst = 1'b0;
        #1;
        check_outputs("mr in_reset", 4'b0000, 1'b0, 4'b0000, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        m_valid = 4'b0011;
        m_len = 32'h0;
        #1;
        chk("mr post idle grant", 64'(grant), 64'h0);
        @(negedge clk);
        #1;
        check_outputs("mr post beat", 4'b0001, 1'b1, 4'b0001, 8'd0);
        @(negedge clk);
        m_valid = 4'b0000;
        #1;
        chk("mr post done grant", 64'(grant), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
